// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - opcode, condition, flag-index and output-register state definitions
package execute_stage_pkg;

    // Data-processing opcodes in encoding order 0..F.
    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR, OP_SUB, OP_RSB,
        OP_ADD,        OP_ADC, OP_SBC, OP_RSC,
        OP_TST,        OP_TEQ, OP_CMP, OP_CMN,
        OP_ORR,        OP_MOV, OP_BIC, OP_MVN
    } opcode_e;

    // Condition field encodings; NV (1111) never passes.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE, COND_CS, COND_CC,
        COND_MI,        COND_PL, COND_VS, COND_VC,
        COND_HI,        COND_LS, COND_GE, COND_LT,
        COND_GT,        COND_LE, COND_AL, COND_NV
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        OREG_EMPTY = 1'b0,
        OREG_FULL  = 1'b1
    } oreg_state_e;

    // TST/TEQ/CMP/CMN occupy 8..B: they always set flags and never write Rd.
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // Opcodes whose flags come from the adder rather than the logic unit.
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= 4'h2 && op <= 4'h7) || op == 4'hA || op == 4'hB;
    endfunction

endpackage

// File: rtl/execute_stage_condition_check.sv
// rtl/execute_stage_condition_check.sv - combinational ARM condition-field evaluator
// Ports: in_Cond (4-bit condition field), in_Flags ({N,Z,C,V}), out_Pass (1 = execute).
module condition_check
    import execute_stage_pkg::*;
(
    input  logic [3:0] in_Cond,
    input  logic [3:0] in_Flags,
    output logic       out_Pass
);

    logic n, z, c, v;
    cond_e cond;

    assign n    = in_Flags[FLAG_N];
    assign z    = in_Flags[FLAG_Z];
    assign c    = in_Flags[FLAG_C];
    assign v    = in_Flags[FLAG_V];
    assign cond = cond_e'(in_Cond);

    always_comb begin
        out_Pass = 1'b0;
        case (cond)
            COND_EQ: out_Pass = z;
            COND_NE: out_Pass = !z;
            COND_CS: out_Pass = c;
            COND_CC: out_Pass = !c;
            COND_MI: out_Pass = n;
            COND_PL: out_Pass = !n;
            COND_VS: out_Pass = v;
            COND_VC: out_Pass = !v;
            COND_HI: out_Pass = c & !z;
            COND_LS: out_Pass = !c | z;
            COND_GE: out_Pass = (n == v);
            COND_LT: out_Pass = (n != v);
            COND_GT: out_Pass = !z & (n == v);
            COND_LE: out_Pass = z | (n != v);
            COND_AL: out_Pass = 1'b1;
            COND_NV: out_Pass = 1'b0;
            default: out_Pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - data-processing execute stage with NZCV register and one-entry output register
// Ports: in_Clk/in_Rst (sync active-high); upstream in_Valid/out_Ready with in_Cond, in_Opcode,
// in_S, in_Rd, in_Rn_val, in_Op2, in_Shift_carry; out_C_flag back to the shifter; out_Flags {N,Z,C,V};
// downstream out_Valid/in_Ready with out_Result, out_Rd, out_Wr_en.
// Optional macro EXEC_PERF_COUNT_EN adds out_Exec_count / out_Skip_count (condition pass / fail accepts).
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 4
) (
    input  logic             in_Clk,
    input  logic             in_Rst,
    input  logic             in_Valid,
    output logic             out_Ready,
    input  logic [3:0]       in_Cond,
    input  logic [3:0]       in_Opcode,
    input  logic             in_S,
    input  logic [RADDR-1:0] in_Rd,
    input  logic [WIDTH-1:0] in_Rn_val,
    input  logic [WIDTH-1:0] in_Op2,
    input  logic             in_Shift_carry,
    output logic             out_C_flag,
    output logic [3:0]       out_Flags,
    output logic             out_Valid,
    input  logic             in_Ready,
    output logic [WIDTH-1:0] out_Result,
    output logic [RADDR-1:0] out_Rd,
    output logic             out_Wr_en
`ifdef EXEC_PERF_COUNT_EN
    ,
    output logic [31:0]      out_Exec_count,
    output logic [31:0]      out_Skip_count
`endif
);

    oreg_state_e      state_q, state_d;
    opcode_e          op;
    logic             accept;
    logic             cond_pass;
    logic [3:0]       flags_q, flags_d;
    logic             set_flags;

    logic [WIDTH-1:0] add_a, add_b;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic             add_ovf;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] alu_res;

    assign op        = opcode_e'(in_Opcode);
    assign accept    = in_Valid & out_Ready;
    assign set_flags = accept & cond_pass & (in_S | is_compare(in_Opcode));

    condition_check u_condition_check (
        .in_Cond  (in_Cond),
        .in_Flags (flags_q),
        .out_Pass (cond_pass)
    );

    // Operand steering: every arithmetic opcode is a single add of (a + b + cin);
    // subtraction uses the inverted operand so C=1 means "no borrow".
    always_comb begin
        add_a   = in_Rn_val;
        add_b   = in_Op2;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                add_b   = ~in_Op2;
                add_cin = 1'b1;
            end
            OP_RSB: begin
                add_a   = in_Op2;
                add_b   = ~in_Rn_val;
                add_cin = 1'b1;
            end
            OP_ADC: add_cin = flags_q[FLAG_C];
            OP_SBC: begin
                add_b   = ~in_Op2;
                add_cin = flags_q[FLAG_C];
            end
            OP_RSC: begin
                add_a   = in_Op2;
                add_b   = ~in_Rn_val;
                add_cin = flags_q[FLAG_C];
            end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != add_a[WIDTH-1]);

    always_comb begin
        logic_res = in_Op2;
        case (op)
            OP_AND, OP_TST: logic_res = in_Rn_val & in_Op2;
            OP_EOR, OP_TEQ: logic_res = in_Rn_val ^ in_Op2;
            OP_ORR:         logic_res = in_Rn_val | in_Op2;
            OP_MOV:         logic_res = in_Op2;
            OP_BIC:         logic_res = in_Rn_val & ~in_Op2;
            OP_MVN:         logic_res = ~in_Op2;
            default:        logic_res = in_Op2;
        endcase
    end

    assign alu_res = is_arith(in_Opcode) ? add_sum[WIDTH-1:0] : logic_res;

    always_comb begin
        flags_d = flags_q;
        if (set_flags) begin
            flags_d[FLAG_N] = alu_res[WIDTH-1];
            flags_d[FLAG_Z] = (alu_res == '0);
            if (is_arith(in_Opcode)) begin
                flags_d[FLAG_C] = add_sum[WIDTH];
                flags_d[FLAG_V] = add_ovf;
            end else begin
                flags_d[FLAG_C] = in_Shift_carry;
            end
        end
    end

    // Output-register FSM: state register.
    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state_q <= OREG_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output-register FSM: next state.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = OREG_FULL;
        end else if (state_q == OREG_FULL && in_Ready) begin
            state_d = OREG_EMPTY;
        end
    end

    // Output-register FSM: outputs.
    always_comb begin
        out_Valid = (state_q == OREG_FULL);
        out_Ready = !out_Valid | in_Ready;
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            flags_q    <= 4'b0000;
            out_Result <= '0;
            out_Rd     <= '0;
            out_Wr_en  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            if (accept) begin
                // A failed condition still occupies the slot so write-back sees it retire.
                out_Result <= alu_res;
                out_Rd     <= in_Rd;
                out_Wr_en  <= cond_pass & !is_compare(in_Opcode);
            end
        end
    end

    assign out_Flags  = flags_q;
    assign out_C_flag = flags_q[FLAG_C];

`ifdef EXEC_PERF_COUNT_EN
    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            out_Exec_count <= 32'd0;
            out_Skip_count <= 32'd0;
        end else if (accept) begin
            if (cond_pass) begin
                out_Exec_count <= out_Exec_count + 32'd1;
            end else begin
                out_Skip_count <= out_Skip_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against an arithmetic reference model
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [3:0]  cond = 4'hE;
    logic [3:0]  opc = 4'h0;
    logic        s_bit = 1'b0;
    logic [3:0]  rd = 4'h0;
    logic [31:0] rn = 32'h0;
    logic [31:0] op2 = 32'h0;
    logic        sc = 1'b0;
    logic        c_flag;
    logic [3:0]  flags;
    logic        out_valid;
    logic        in_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  out_rd;
    logic        wr_en;
`ifdef EXEC_PERF_COUNT_EN
    logic [31:0] exec_count, skip_count;
`endif

    execute_stage #(.WIDTH(32), .RADDR(4)) dut (
        .in_Clk         (clk),
        .in_Rst         (rst),
        .in_Valid       (in_valid),
        .out_Ready      (out_ready),
        .in_Cond        (cond),
        .in_Opcode      (opc),
        .in_S           (s_bit),
        .in_Rd          (rd),
        .in_Rn_val      (rn),
        .in_Op2         (op2),
        .in_Shift_carry (sc),
        .out_C_flag     (c_flag),
        .out_Flags      (flags),
        .out_Valid      (out_valid),
        .in_Ready       (in_ready),
        .out_Result     (result),
        .out_Rd         (out_rd),
        .out_Wr_en      (wr_en)
`ifdef EXEC_PERF_COUNT_EN
        ,
        .out_Exec_count (exec_count),
        .out_Skip_count (skip_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference state: what write-back and the flag register should hold.
    logic        m_valid = 1'b0;
    logic [31:0] m_res = 32'h0;
    logic [3:0]  m_rd = 4'h0;
    logic        m_wr = 1'b0;
    logic        m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;
    logic [31:0] m_exec = 32'h0, m_skip = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic cond_ok(input logic [3:0] c4);
        case (c4)
            4'd0:  return m_z;
            4'd1:  return !m_z;
            4'd2:  return m_c;
            4'd3:  return !m_c;
            4'd4:  return m_n;
            4'd5:  return !m_n;
            4'd6:  return m_v;
            4'd7:  return !m_v;
            4'd8:  return m_c && !m_z;
            4'd9:  return !m_c || m_z;
            4'd10: return m_n == m_v;
            4'd11: return m_n != m_v;
            4'd12: return !m_z && (m_n == m_v);
            4'd13: return m_z || (m_n != m_v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Executes one accepted instruction with plain integer arithmetic.
    function automatic void model_exec(input logic [3:0] c4, input logic [3:0] o, input logic s,
                                       input logic [3:0] d, input logic [31:0] a, input logic [31:0] b,
                                       input logic shc);
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint nb = m_c ? 0 : 1;
        longint us = 0, ss = 0;
        logic   arith = 1'b1;
        logic   pass, cmp, nc;
        logic [31:0] r = 32'h0;
        pass = cond_ok(c4);
        cmp  = (o >= 4'd8 && o <= 4'd11);
        nc   = m_c;
        case (o)
            4'd2, 4'd10: begin us = ua - ub;      nc = (ua >= ub);      ss = sa - sb;      end
            4'd3:        begin us = ub - ua;      nc = (ub >= ua);      ss = sb - sa;      end
            4'd4, 4'd11: begin us = ua + ub;      nc = (us > 64'hFFFFFFFF); ss = sa + sb;  end
            4'd5:        begin us = ua + ub + (1 - nb); nc = (us > 64'hFFFFFFFF); ss = sa + sb + (1 - nb); end
            4'd6:        begin us = ua - ub - nb; nc = (ua >= ub + nb); ss = sa - sb - nb; end
            4'd7:        begin us = ub - ua - nb; nc = (ub >= ua + nb); ss = sb - sa - nb; end
            default: begin
                arith = 1'b0;
                nc = shc;
                case (o)
                    4'd0, 4'd8:  r = a & b;
                    4'd1, 4'd9:  r = a ^ b;
                    4'd12:       r = a | b;
                    4'd13:       r = b;
                    4'd14:       r = a & ~b;
                    default:     r = ~b;
                endcase
            end
        endcase
        if (arith) r = us[31:0];
        if (pass && (s || cmp)) begin
            m_n = r[31];
            m_z = (r == 32'h0);
            m_c = nc;
            if (arith) m_v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
        if (pass) m_exec = m_exec + 32'd1;
        else      m_skip = m_skip + 32'd1;
        m_valid = 1'b1;
        m_res   = r;
        m_rd    = d;
        m_wr    = pass && !cmp;
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        chk("out_result", result, m_res);
        chk("out_rd", {28'h0, out_rd}, {28'h0, m_rd});
        chk("out_wr_en", {31'h0, wr_en}, {31'h0, m_wr});
        chk("out_flags", {28'h0, flags}, {28'h0, m_n, m_z, m_c, m_v});
        chk("out_c_flag", {31'h0, c_flag}, {31'h0, m_c});
`ifdef EXEC_PERF_COUNT_EN
        chk("exec_count", exec_count, m_exec);
        chk("skip_count", skip_count, m_skip);
`endif
    endtask

    task automatic step(input logic v, input logic rdy, input logic [3:0] c4, input logic [3:0] o,
                        input logic s, input logic [3:0] d, input logic [31:0] a, input logic [31:0] b,
                        input logic shc);
        logic exp_ready;
        @(negedge clk);
        in_valid = v; in_ready = rdy; cond = c4; opc = o; s_bit = s;
        rd = d; rn = a; op2 = b; sc = shc;
        #1;
        exp_ready = !m_valid || rdy;
        chk("out_ready", {31'h0, out_ready}, {31'h0, exp_ready});
        if (v && exp_ready) model_exec(c4, o, s, d, a, b, shc);
        else if (rdy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic v, input logic rdy);
        @(negedge clk);
        rst = 1'b1; in_valid = v; in_ready = rdy;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_res = 32'h0; m_rd = 4'h0; m_wr = 1'b0;
        m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
        m_exec = 32'h0; m_skip = 32'h0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        do_reset(1'b0, 1'b1);

        // ADDS overflow into the sign bit.
        step(1, 1, 4'hE, 4'h4, 1, 4'd2, 32'h7FFF_FFFF, 32'h1, 0);
        chk("adds_result", result, 32'h8000_0000);
        chk("adds_flags", {28'h0, flags}, 32'h9);
        chk("adds_wr_rd", {27'h0, wr_en, out_rd}, {27'h0, 1'b1, 4'd2});

        // CMP equal, then conditional adds.
        step(1, 1, 4'hE, 4'hA, 0, 4'd1, 32'd5, 32'd5, 0);
        chk("cmp_wr_en", {31'h0, wr_en}, 32'h0);
        chk("cmp_flags", {28'h0, flags}, 32'h6);
        step(1, 1, 4'h0, 4'h4, 0, 4'd3, 32'd1, 32'd2, 0);
        chk("addeq_wr_en", {31'h0, wr_en}, 32'h1);
        step(1, 1, 4'h1, 4'h4, 0, 4'd3, 32'd1, 32'd2, 0);
        chk("addne_wr_en", {31'h0, wr_en}, 32'h0);
        chk("addne_flags", {28'h0, flags}, 32'h6);

        // MOVS keeps V and takes C from the shifter.
        step(1, 1, 4'hE, 4'h4, 1, 4'd2, 32'h7FFF_FFFF, 32'h1, 0);
        step(1, 1, 4'hE, 4'hD, 1, 4'd4, 32'h1234, 32'h0, 1);
        chk("movs_flags", {28'h0, flags}, 32'h7);
        chk("movs_c_flag", {31'h0, c_flag}, 32'h1);

        // SBCS with C=0 then C=1.
        step(1, 1, 4'hE, 4'h4, 1, 4'd5, 32'h0, 32'h0, 0);
        step(1, 1, 4'hE, 4'h6, 1, 4'd5, 32'h0, 32'h0, 0);
        chk("sbcs_c0_result", result, 32'hFFFF_FFFF);
        chk("sbcs_c0_flags", {28'h0, flags}, 32'h8);
        step(1, 1, 4'hE, 4'hA, 0, 4'd0, 32'd5, 32'd5, 0);
        step(1, 1, 4'hE, 4'h6, 1, 4'd5, 32'h0, 32'h0, 0);
        chk("sbcs_c1_result", result, 32'h0);
        chk("sbcs_c1_flags", {28'h0, flags}, 32'h6);

        // Backpressure: two stalled cycles, then release and drain.
        step(1, 0, 4'hE, 4'h4, 1, 4'd6, 32'd10, 32'd20, 0);
        chk("bp_hold_result", result, 32'h0);
        step(1, 0, 4'hE, 4'h4, 1, 4'd6, 32'd10, 32'd20, 0);
        chk("bp_hold_flags", {28'h0, flags}, 32'h6);
        step(1, 1, 4'hE, 4'h4, 1, 4'd6, 32'd10, 32'd20, 0);
        chk("bp_release_result", result, 32'd30);
        step(0, 1, 4'hE, 4'h4, 1, 4'd6, 32'd10, 32'd20, 0);
        chk("bp_drained", {31'h0, out_valid}, 32'h0);

        // Reset while FULL and stalled.
        step(1, 1, 4'hE, 4'h4, 1, 4'd7, 32'd1, 32'd1, 0);
        step(0, 0, 4'hE, 4'h4, 1, 4'd7, 32'd1, 32'd1, 0);
        do_reset(1'b1, 1'b0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rc;
            rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rc,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Data-processing execute stage directly downstream of the operand-2 barrel shifter.
- Consumes the shifted operand and the shifter carry-out.
- Evaluates the ARM condition field, performs the 16 data-processing opcodes, owns the NZCV flag register and feeds the current C flag back to the shifter.
- Result is held in a one-entry output register with valid/ready handshake toward write-back.

Parameters:
- WIDTH, 32 (`WordWidth), datapath width.
- RADDR, 4, register index width.

Ports:
- in_Clk  input  1  clock.
- in_Rst  input  1  synchronous active-high reset.
- in_Valid  input  1  upstream instruction valid.
- out_Ready  output  1  stage can accept this cycle.
- in_Cond  input  4  condition field.
- in_Opcode  input  4  data-processing opcode.
- in_S  input  1  set-flags bit.
- in_Rd  input  RADDR  destination register.
- in_Rn_val  input  WIDTH  first operand.
- in_Op2  input  WIDTH  shifter output operand.
- in_Shift_carry  input  1  shifter carry-out.
- out_C_flag  output  1  registered C flag to shifter in_C_flag.
- out_Flags  output  4  registered {N,Z,C,V}.
- out_Valid  output  1  output register holds a result.
- in_Ready  input  1  write-back accepts.
- out_Result  output  WIDTH  ALU result.
- out_Rd  output  RADDR  destination register.
- out_Wr_en  output  1  result must be written to out_Rd.

Behaviour:
- One clock (in_Clk); reset synchronous, active-high (in_Rst).
- Reset values: out_Valid=0, out_Flags=0000, out_Result=0, out_Rd=0, out_Wr_en=0.
- Output register states:
  - EMPTY (out_Valid=0).
  - FULL (out_Valid=1).
  - out_Ready = !out_Valid | in_Ready (combinational).
- Accept = in_Valid & out_Ready. On the accept edge the output register loads, and the state becomes or stays FULL.
- FULL & in_Ready & !accept -> EMPTY.
- FULL & !in_Ready: hold all outputs stable; no flag update.
- Latency: 1 cycle from accept to out_Valid. Full throughput: accept every cycle while in_Ready=1.
- Condition is evaluated combinationally against the registered flags:
  - Codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - 1111 = never.
  - Condition fail: the result register still loads (out_Valid=1) with out_Wr_en=0; flags unchanged.
- Opcode encodings 0..F: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
  - SUB = Rn+~Op2+1; RSB = Op2+~Rn+1; SBC = Rn+~Op2+C; RSC = Op2+~Rn+C.
  - Arithmetic is performed on a WIDTH+1 adder.
- Flag rules:
  - Flags update only on accept & condition pass & (in_S | opcode is TST/TEQ/CMP/CMN).
  - N = result[WIDTH-1]; Z = (result==0).
  - Arithmetic ops: C = adder carry-out (subtract: C=1 means no borrow); V = signed overflow of the actual adder operands.
  - Logical ops: C = in_Shift_carry; V unchanged.
- TST/TEQ/CMP/CMN: out_Wr_en=0 always; out_Result still shows the computed value.
- Simultaneous flag-setting instructions back to back: the second instruction's condition and ADC/SBC/RSC carry see the flags written by the first (registered on the first's accept edge).
- Rd=15 gets no special handling (no CPSR restore).
- Reset mid-operation: any held result is discarded and flags are cleared, regardless of in_Ready.

Optional Feature:
- EXEC_PERF_COUNT_EN:
  - Defined: adds outputs out_Exec_count[31:0] and out_Skip_count[31:0], both reset to 0.
  - Exec increments on accept with condition pass; Skip increments on accept with condition fail.
  - Both wrap 0xFFFFFFFF -> 0.
  - Undefined: the ports and counters are absent.

Decomposition:
- Shared include Def_Alu.v: opcode defines (`OpAND..`OpMVN), condition defines (`CondEQ..`CondNV), flag bit indices (`FlagN=3, `FlagZ=2, `FlagC=1, `FlagV=0). Uses the existing `WordWidth from Def_StructureParameter.v.
- One sub-module, condition_check: combinational, in_Cond + in_Flags -> out_Pass.

Test Plan:
- Reset then ADDS Rn=0x7FFFFFFF, Op2=1, Rd=2 -> next cycle out_Result=0x80000000, out_Wr_en=1, out_Rd=2, flags N=1 Z=0 C=0 V=1.
- CMP Rn=5, Op2=5 (S implied) -> out_Wr_en=0, flags Z=1 C=1 N=0 V=0; following ADDEQ executes (out_Wr_en=1); following ADDNE gets out_Wr_en=0 with flags unchanged.
- MOVS Op2=0, in_Shift_carry=1 with prior V=1 -> out_Result=0, Z=1 C=1 V=1 (V preserved); out_C_flag=1 the cycle after.
- SBCS Rn=0, Op2=0 with C=0 -> out_Result=0xFFFFFFFF, N=1 C=0; with C=1 -> out_Result=0, Z=1 C=1.
- Backpressure: hold in_Ready=0 two cycles with in_Valid=1 -> out_Ready=0, outputs and flags stable; release -> next instruction accepted, no instruction lost or duplicated.
- Assert in_Rst while FULL and in_Ready=0 -> next cycle out_Valid=0, out_Flags=0000; with EXEC_PERF_COUNT_EN both counters read 0.
